// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - execute stage: forwarding, ALU, iterative multiplier, branch resolve, EXE/MEM register
// Optional EXE_OVF_EN adds a registered signed add/sub overflow flag (ovf_exc).
module exe_stage_mc #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MUL_BPC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [1:0]        fwd_st_sel,
  input  logic [3:0]        exe_cmd,
  input  logic [1:0]        br_type,
  input  logic              wb_en_in,
  input  logic [1:0]        mem_sig_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] fwd_alu,
  input  logic [DATA_W-1:0] fwd_wb,
  output logic              stall_out,
  output logic [DATA_W-1:0] br_addr,
  output logic              br_taken,
  output logic              wb_en,
  output logic [1:0]        mem_sig,
  output logic [REG_AW-1:0] dest,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_data
`ifdef EXE_OVF_EN
  ,
  output logic              ovf_exc
`endif
);

  localparam int N     = DATA_W / MUL_BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] res;
    case (sel)
      2'd1:    res = a;
      2'd2:    res = w;
      default: res = r;
    endcase
    return res;
  endfunction

  logic [DATA_W-1:0] op_a, op_b, op_st;
  logic [DATA_W-1:0] sum_res, diff_res, alu_out;
  logic [SH_W-1:0]   shamt;

  always_comb begin
    op_a     = fwd_mux(fwd_a_sel, val1, fwd_alu, fwd_wb);
    op_b     = fwd_mux(fwd_b_sel, val2, fwd_alu, fwd_wb);
    op_st    = fwd_mux(fwd_st_sel, reg2, fwd_alu, fwd_wb);
    sum_res  = op_a + op_b;
    diff_res = op_a - op_b;
    shamt    = op_b[SH_W-1:0];
    case (exe_cmd)
      OP_ADD:  alu_out = sum_res;
      OP_SUB:  alu_out = diff_res;
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_NOR:  alu_out = ~(op_a | op_b);
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_SLL:  alu_out = op_a << shamt;
      OP_SRA:  alu_out = $signed(op_a) >>> shamt;
      OP_SRL:  alu_out = op_a >> shamt;
      default: alu_out = '0;
    endcase
  end

  // Branch target uses the raw immediate in val2, never a forwarded value
  always_comb begin
    br_addr = pc_in + {val2[DATA_W-1:2], 2'b00};
    case (br_type)
      2'd1:    br_taken = (op_a == '0);
      2'd2:    br_taken = (op_a != op_st);
      2'd3:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
    br_taken = br_taken & in_valid & ~flush;
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic [DATA_W-1:0] pp_sum, acc_sum;
  logic              mul_accept, mul_last;

  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (mb_q[j]) pp_sum = pp_sum + (ma_q << j);
    end
    acc_sum    = acc_q + pp_sum;
    mul_accept = (state_q == S_IDLE) & in_valid & (exe_cmd == OP_MUL) & ~flush & ~mem_stall;
    mul_last   = (state_q == S_BUSY) & (cnt_q == CNT_LAST);
    stall_out  = mem_stall | mul_accept | ((state_q == S_BUSY) & ~flush & ~mul_last);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (mul_accept) begin
          ma_d    = op_a;
          mb_d    = op_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (!mem_stall) begin
          acc_d = acc_sum;
          ma_d  = ma_q << MUL_BPC;
          mb_d  = mb_q >> MUL_BPC;
          cnt_d = cnt_q + CNT_W'(1);
          if (mul_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic              wb_en_q, wb_en_d;
  logic [1:0]        mem_sig_q, mem_sig_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] pc_out_q, pc_out_d, alu_res_q, alu_res_d, st_data_q, st_data_d;
`ifdef EXE_OVF_EN
  logic              ovf_exc_q, ovf_exc_d, alu_ovf;
  localparam int MSB = DATA_W - 1;

  always_comb begin
    alu_ovf = ((exe_cmd == OP_ADD) & (op_a[MSB] == op_b[MSB]) & (sum_res[MSB] != op_a[MSB])) |
              ((exe_cmd == OP_SUB) & (op_a[MSB] != op_b[MSB]) & (diff_res[MSB] != op_a[MSB]));
  end
`endif

  // Every non-stalled cycle loads either a real result or a bubble
  always_comb begin
    wb_en_d   = wb_en_q;
    mem_sig_d = mem_sig_q;
    dest_d    = dest_q;
    pc_out_d  = pc_out_q;
    alu_res_d = alu_res_q;
    st_data_d = st_data_q;
`ifdef EXE_OVF_EN
    ovf_exc_d = ovf_exc_q;
`endif
    if (!mem_stall) begin
      wb_en_d   = 1'b0;
      mem_sig_d = 2'b00;
      dest_d    = '0;
      pc_out_d  = '0;
      alu_res_d = '0;
      st_data_d = '0;
`ifdef EXE_OVF_EN
      ovf_exc_d = 1'b0;
`endif
      if (flush) begin
        wb_en_d = 1'b0;
      end else if (state_q == S_BUSY) begin
        if (mul_last) begin
          wb_en_d   = wb_en_in;
          mem_sig_d = mem_sig_in;
          dest_d    = dest_in;
          pc_out_d  = pc_in;
          alu_res_d = acc_sum;
          st_data_d = op_st;
        end
      end else if (in_valid && !mul_accept) begin
        wb_en_d   = wb_en_in;
        mem_sig_d = mem_sig_in;
        dest_d    = dest_in;
        pc_out_d  = pc_in;
        alu_res_d = alu_out;
        st_data_d = op_st;
`ifdef EXE_OVF_EN
        ovf_exc_d = alu_ovf;
        if (alu_ovf) begin
          wb_en_d   = 1'b0;
          mem_sig_d = 2'b00;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      wb_en_q   <= 1'b0;
      mem_sig_q <= 2'b00;
      dest_q    <= '0;
      pc_out_q  <= '0;
      alu_res_q <= '0;
      st_data_q <= '0;
`ifdef EXE_OVF_EN
      ovf_exc_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      wb_en_q   <= wb_en_d;
      mem_sig_q <= mem_sig_d;
      dest_q    <= dest_d;
      pc_out_q  <= pc_out_d;
      alu_res_q <= alu_res_d;
      st_data_q <= st_data_d;
`ifdef EXE_OVF_EN
      ovf_exc_q <= ovf_exc_d;
`endif
    end
  end

  assign wb_en   = wb_en_q;
  assign mem_sig = mem_sig_q;
  assign dest    = dest_q;
  assign pc_out  = pc_out_q;
  assign alu_res = alu_res_q;
  assign st_data = st_data_q;
`ifdef EXE_OVF_EN
  assign ovf_exc = ovf_exc_q;
`endif

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - scoreboard bench for exe_stage_mc
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, mem_stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_st_sel;
  logic [3:0]  exe_cmd;
  logic [1:0]  br_type;
  logic        wb_en_in;
  logic [1:0]  mem_sig_in;
  logic [4:0]  dest_in;
  logic [31:0] val1, val2, reg2, pc_in, fwd_alu, fwd_wb;
  logic        stall_out, br_taken, wb_en;
  logic [31:0] br_addr, pc_out, alu_res, st_data;
  logic [1:0]  mem_sig;
  logic [4:0]  dest;

  exe_stage_mc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .mem_stall(mem_stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_st_sel(fwd_st_sel),
    .exe_cmd(exe_cmd), .br_type(br_type), .wb_en_in(wb_en_in), .mem_sig_in(mem_sig_in),
    .dest_in(dest_in), .val1(val1), .val2(val2), .reg2(reg2), .pc_in(pc_in),
    .fwd_alu(fwd_alu), .fwd_wb(fwd_wb), .stall_out(stall_out), .br_addr(br_addr),
    .br_taken(br_taken), .wb_en(wb_en), .mem_sig(mem_sig), .dest(dest),
    .pc_out(pc_out), .alu_res(alu_res), .st_data(st_data)
  );

  always #5 clk = ~clk;

  localparam int S_ALU = 0, S_WB = 1, S_MEM = 2, S_DEST = 3, S_STALL = 4,
                 S_BRT = 5, S_BRA = 6, S_PC = 7, S_ST = 8;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   drain = 0;
  bit   stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_ALU:   return alu_res;
      S_WB:    return {31'b0, wb_en};
      S_MEM:   return {30'b0, mem_sig};
      S_DEST:  return {27'b0, dest};
      S_STALL: return {31'b0, stall_out};
      S_BRT:   return {31'b0, br_taken};
      S_BRA:   return br_addr;
      S_PC:    return pc_out;
      default: return st_data;
    endcase
  endfunction

  task automatic chk(input int dc, input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: pops every expectation due this cycle and compares it
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = actual(q[i].sig);
        n_chk++;
        if (act !== q[i].val || q[i].cyc != cyc) begin
          n_fail++;
          $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", q[i].name, q[i].cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
    if (stim_done) begin
      drain++;
      if (q.size() == 0 || drain > 5) begin
        foreach (q[i]) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s never sampled (due cyc %0d)", q[i].name, q[i].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  task automatic idle();
    in_valid = 0; flush = 0; mem_stall = 0;
    fwd_a_sel = 0; fwd_b_sel = 0; fwd_st_sel = 0;
    exe_cmd = 0; br_type = 0; wb_en_in = 0; mem_sig_in = 0; dest_in = 0;
    val1 = 0; val2 = 0; reg2 = 0; pc_in = 0; fwd_alu = 0; fwd_wb = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    idle();
    in_valid = 1; exe_cmd = 4'b0011; val1 = a; val2 = b; wb_en_in = 1; dest_in = d;
  endtask

  logic [3:0]  alu_ops [8] = '{4'b0100, 4'b0101, 4'b0111, 4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1111};
  logic [31:0] alu_exp [8] = '{32'h0000_00E0, 32'h8000_0FF4, 32'h8000_0F14, 32'h7FFF_F00B,
                              32'h0000_0F00, 32'hF800_000F, 32'h0800_000F, 32'h0000_0000};

  initial begin
    idle();
    rst = 1;
    step();
    step();
    chk(0, S_ALU, 0, "rst_alu");
    chk(0, S_WB, 0, "rst_wb");
    chk(0, S_STALL, 0, "rst_stall");
    rst = 0;

    step();
    in_valid = 1; exe_cmd = 4'b0000; val1 = 5; val2 = 7; wb_en_in = 1;
    mem_sig_in = 2'b10; dest_in = 3; pc_in = 32'h40; reg2 = 32'h55;
    chk(0, S_STALL, 0, "add_stall");
    chk(1, S_ALU, 12, "add_res");
    chk(1, S_WB, 1, "add_wb");
    chk(1, S_MEM, 2, "add_mem");
    chk(1, S_DEST, 3, "add_dest");
    chk(1, S_PC, 32'h40, "add_pc");
    chk(1, S_ST, 32'h55, "add_st");

    step();
    exe_cmd = 4'b0010; fwd_a_sel = 1; fwd_alu = 100; val1 = 999; val2 = 1;
    chk(1, S_ALU, 99, "sub_fwd_alu");
    step();
    fwd_a_sel = 2; fwd_wb = 50; fwd_st_sel = 2;
    chk(1, S_ALU, 49, "sub_fwd_wb");
    chk(1, S_ST, 50, "st_fwd_wb");
    step();
    exe_cmd = 4'b0000; fwd_a_sel = 0; val1 = 10; fwd_b_sel = 1; fwd_alu = 20; val2 = 3;
    fwd_st_sel = 3; reg2 = 32'h77;
    chk(1, S_ALU, 30, "add_fwd_b");
    chk(1, S_ST, 32'h77, "st_sel3");

    for (int k = 0; k < 8; k++) begin
      step();
      idle();
      in_valid = 1; exe_cmd = alu_ops[k]; val1 = 32'h8000_00F0; val2 = 32'h0000_0FE4;
      chk(1, S_ALU, alu_exp[k], $sformatf("alu_op%0h", alu_ops[k]));
    end

    step();
    idle();
    chk(1, S_ALU, 0, "bubble_alu");
    chk(1, S_WB, 0, "bubble_wb");

    step();
    in_valid = 1; exe_cmd = 4'b0000; val1 = 1; val2 = 2; wb_en_in = 1;
    chk(1, S_ALU, 3, "pre_hold_alu");
    step();
    idle();
    mem_stall = 1;
    chk(0, S_STALL, 1, "hold_stall");
    chk(1, S_ALU, 3, "hold_alu");
    chk(1, S_WB, 1, "hold_wb");

    step();
    mul_op(32'h1234_5678, 32'h5, 7);
    fwd_a_sel = 1; fwd_alu = 32'h0001_0003;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) step();
      if (i == 5) fwd_alu = 32'hDEAD_BEEF;
      chk(0, S_STALL, (i < 16) ? 32'd1 : 32'd0, $sformatf("mul1_stall%0d", i));
      if (i >= 1) chk(0, S_WB, 0, $sformatf("mul1_bub%0d", i));
    end
    chk(1, S_ALU, 32'h0005_000F, "mul1_res");
    chk(1, S_WB, 1, "mul1_wb");
    chk(1, S_DEST, 7, "mul1_dest");
    step();
    idle();

    step();
    mul_op(7, 9, 9);
    for (int i = 0; i <= 19; i++) begin
      if (i > 0) step();
      mem_stall = (i >= 5 && i <= 7);
      chk(0, S_STALL, (i < 19) ? 32'd1 : 32'd0, $sformatf("mul2_stall%0d", i));
      if (i >= 1) chk(0, S_ALU, 0, $sformatf("mul2_hold%0d", i));
    end
    mem_stall = 0;
    chk(1, S_ALU, 63, "mul2_res");
    chk(1, S_DEST, 9, "mul2_dest");
    step();
    idle();

    step();
    mul_op(3, 4, 5);
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) step();
      if (i == 5) flush = 1;
      else chk(0, S_STALL, 1, $sformatf("mul3_stall%0d", i));
    end
    step();
    idle();
    chk(0, S_STALL, 0, "flush_stall");
    chk(0, S_WB, 0, "flush_bub_wb");
    chk(0, S_ALU, 0, "flush_bub_alu");
    for (int k = 0; k < 14; k++) begin
      step();
      chk(0, S_ALU, 0, $sformatf("flush_nores%0d", k));
    end

    step();
    in_valid = 1; exe_cmd = 4'b0000; val1 = 4; val2 = 4; wb_en_in = 1; pc_in = 32'h80;
    step();
    mul_op(3, 4, 5);
    for (int i = 0; i < 4; i++) step();
    rst = 1;
    step();
    rst = 0;
    idle();
    chk(0, S_STALL, 0, "rstb_stall");
    chk(0, S_ALU, 0, "rstb_alu");
    chk(0, S_WB, 0, "rstb_wb");
    chk(0, S_PC, 0, "rstb_pc");
    for (int k = 0; k < 16; k++) step();
    chk(0, S_WB, 0, "rstb_nores");

    step();
    in_valid = 1; br_type = 2; val1 = 3; reg2 = 3; pc_in = 32'h100; val2 = 32'h13;
    chk(0, S_BRT, 0, "bne_eq");
    chk(0, S_BRA, 32'h110, "br_addr");
    step();
    fwd_st_sel = 1; fwd_alu = 4;
    chk(0, S_BRT, 1, "bne_fwd_ne");
    step();
    br_type = 1; val1 = 0;
    chk(0, S_BRT, 1, "bez_zero");
    step();
    val1 = 1;
    chk(0, S_BRT, 0, "bez_nonzero");
    step();
    br_type = 3; flush = 1;
    chk(0, S_BRT, 0, "jmp_flush");
    step();
    flush = 0;
    chk(0, S_BRT, 1, "jmp");
    step();
    in_valid = 0;
    chk(0, S_BRT, 0, "jmp_invalid");

    step();
    idle();
    step();
    stim_done = 1'b1;
  end

endmodule
